ddc_hop_scheduler: RTL and testbench
====================================

Name: ddc_hop_scheduler

Overview:
- Frequency-hopping controller for the receive DDC/DUC mixers; owns the `ddc_phase_inc` that feeds the DDS of the IQ frequency shifter.
- Holds a programmable table of phase increments and steps through it on a fixed dwell schedule.
- Inserts a mute/guard window around every retune so downstream sample consumers can blank DDS phase transients.
- Sits between the control-register block and `rx_baseband_receiver`; one clock domain shared with the datapath.

Parameters:
- TABLE_DEPTH, 16, number of hop-table entries (power of two, ≥2).
- PHASE_W, 16, width of a phase increment word.
- DWELL_W, 32, width of the dwell counter and its config input.
- GUARD_W, 16, width of the guard counter and its config input.

Ports:
- clock  in  1  datapath clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- cfg_we  in  1  hop-table write strobe.
- cfg_addr  in  $clog2(TABLE_DEPTH)  hop-table write address.
- cfg_data  in  PHASE_W  phase increment to store.
- hop_len  in  $clog2(TABLE_DEPTH)+1  active entries, 1..TABLE_DEPTH; sampled at start.
- dwell_cycles  in  DWELL_W  unmuted cycles per hop; sampled at start.
- guard_cycles  in  GUARD_W  muted settle cycles after each retune; sampled at start.
- start  in  1  begin hopping from entry 0; level or pulse, acted on only in IDLE.
- stop  in  1  abort hopping.
- ddc_phase_inc  out  PHASE_W  current phase increment to the DDS.
- phase_inc_valid  out  1  one-cycle pulse when `ddc_phase_inc` changes.
- mute  out  1  high whenever the output frequency is not settled.
- busy  out  1  high when the FSM is not in IDLE.
- hop_index  out  $clog2(TABLE_DEPTH)  table entry currently applied.
- hop_count  out  32  hops completed since last start; wraps.

Behaviour:
- Reset values: all outputs 0 except `mute`=1. State=IDLE. Table contents are undefined after reset (RAM is not cleared).
- Table writes:
  - Accepted in any state.
  - A write to the entry currently being read lands on the next LOAD of that entry, not the current one.
- Config snapshot: `hop_len`, `dwell_cycles` and `guard_cycles` are latched at the start edge. Changes while busy are ignored.
  - `hop_len`=0 is treated as 1; `hop_len`>TABLE_DEPTH is clamped to TABLE_DEPTH.
  - `dwell_cycles`=0 is treated as 1.
- FSM states: IDLE, LOAD, APPLY, GUARD, DWELL.
- IDLE: `mute`=1, `busy`=0, outputs hold. On `start`=1 and `stop`=0: idx←0, `hop_count`←0, go to LOAD.
- LOAD (1 cycle): table read address=idx (synchronous read). Next state APPLY.
- APPLY (1 cycle): read data registered into `ddc_phase_inc`, `hop_index`←idx. `phase_inc_valid`=1 in the following cycle.
  - Latency: start sampled at edge N → new `ddc_phase_inc` visible and `phase_inc_valid`=1 from cycle N+3.
- GUARD: count `guard_cycles` cycles, then go to DWELL. If `guard_cycles`=0, go directly APPLY→DWELL.
- DWELL: count `dwell_cycles` cycles. On the final dwell cycle:
  - `hop_count`++;
  - idx←(idx==hop_len-1)?0:idx+1;
  - go to LOAD.
  - Hop period = 2+guard+dwell cycles.
- `mute`=1 in all states except DWELL.
- `stop`=1 in any non-IDLE state: next cycle IDLE, `mute`=1, `ddc_phase_inc` holds its last value, no `phase_inc_valid` pulse.
  - `stop` has priority over a same-cycle `start`.
  - If a hop completes in the same cycle as `stop`, `hop_count` does not increment.
- `resetn`=0 mid-operation: on the next edge, all outputs return to their reset values.
- All counters are unsigned. The dwell and guard counters load N-1 and decrement to 0.

Optional Feature:
- Macro: DDC_HOP_PRBS_ORDER_EN.
- Defined:
  - Next idx comes from a 7-bit Fibonacci LFSR (x^7+x^6+1, seed 7'h01 at start), advanced once per hop.
  - idx = lfsr mod hop_len. A remainder equal to the current idx is replaced by (idx+1) mod hop_len, so consecutive hops always differ when hop_len>1.
  - Remainder is computed by repeated subtraction over ≤7 conditional steps, combinational, inside DWELL.
- Undefined: sequential order as described in Behaviour; no LFSR logic is present.

Decomposition:
- Package `ddc_hop_pkg`: FSM state enum `hop_state_t`; LFSR taps and seed constants; default widths.
- Sub-module `hop_table_ram`: simple dual-port RAM, write port on `cfg_*`, synchronous one-cycle read.
- Top level contains the FSM and counters.

Test Plan:
- Table = {0x1000,0x2000,0x3000}, hop_len=3, dwell=4, guard=2, start pulse → outputs 0x1000,0x2000,0x3000,0x1000 with `phase_inc_valid` spaced 8 cycles apart. First value at start+3. `mute` low exactly 4 cycles per hop. `hop_count`=3 after 24 cycles.
- guard=0, dwell=0 → hop every 3 cycles, `mute` low 1 cycle per hop. hop_len=0 → only entry 0 is applied, repeatedly.
- `stop` asserted during GUARD of hop 2 → IDLE next cycle, `mute`=1, `ddc_phase_inc` holds 0x2000, `hop_count`=1.
- Write 0xBEEF to entry 1 while entry 1 is in DWELL → current output unchanged; next visit to entry 1 outputs 0xBEEF.
- `resetn` low for 1 cycle during DWELL → all outputs 0, `mute`=1, `busy`=0 on the next cycle. `start` afterwards restarts at entry 0.
- DDC_HOP_PRBS_ORDER_EN, hop_len=5, 64 hops → sequence matches the reference LFSR model, never repeats the same idx back-to-back, all idx<5.

Source files
------------

// File: rtl/ddc_hop_pkg.sv
//==============================================================================
// Module      : ddc_hop_pkg
// Description : Shared types and constants for the DDC frequency-hop
//               scheduler: FSM state encoding, LFSR seed/taps and default
//               widths, plus the modulo helper used by the pseudo-random
//               hop order (DDC_HOP_PRBS_ORDER_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ddc_hop_pkg;

    // Default widths of the scheduler
    localparam int c_default_table_depth = 16;
    localparam int c_default_phase_w     = 16;
    localparam int c_default_dwell_w     = 32;
    localparam int c_default_guard_w     = 16;

    // Scheduler state encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_APPLY = 3'd2,
        S_GUARD = 3'd3,
        S_DWELL = 3'd4
    } hop_state_t;

    // 7-bit Fibonacci LFSR, polynomial x^7 + x^6 + 1
    localparam logic [6:0] c_lfsr_seed = 7'h01;
    localparam logic [6:0] c_lfsr_taps = 7'h60;

    // Remainder of a 7-bit value by a non-zero modulus using seven
    // conditional subtractions of modulus*2^k (restoring division).
    function automatic logic [31:0] mod_by_subtract(
        input logic [31:0] value,
        input logic [31:0] modulus
    );
        logic [31:0] rem;
        rem = value;
        for (int k = 6; k >= 0; k--) begin
            if (rem >= (modulus << k)) begin
                rem = rem - (modulus << k);
            end
        end
        return rem;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hop_table_ram.sv
//==============================================================================
// Module      : hop_table_ram
// Description : Simple dual-port RAM holding the hop phase increments.
//               Write port driven by configuration, one-cycle synchronous
//               read. A same-address read and write returns the old word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hop_table_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write and registered read; contents are not cleared by reset
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ddc_hop_scheduler.sv
//==============================================================================
// Module      : ddc_hop_scheduler
// Description : Frequency-hop controller for the DDC/DUC mixers. Steps
//               through a programmable table of DDS phase increments with a
//               fixed dwell, muting the output for a guard window after
//               every retune.
//               Optional macro DDC_HOP_PRBS_ORDER_EN selects a pseudo-random
//               hop order (7-bit LFSR) instead of sequential order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddc_hop_scheduler
    import ddc_hop_pkg::*;
#(
    parameter int TABLE_DEPTH = c_default_table_depth,
    parameter int PHASE_W     = c_default_phase_w,
    parameter int DWELL_W     = c_default_dwell_w,
    parameter int GUARD_W     = c_default_guard_w
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           cfg_we,
    input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_addr,
    input  logic [PHASE_W-1:0]             cfg_data,
    input  logic [$clog2(TABLE_DEPTH):0]   hop_len,
    input  logic [DWELL_W-1:0]             dwell_cycles,
    input  logic [GUARD_W-1:0]             guard_cycles,
    input  logic                           start,
    input  logic                           stop,
    output logic [PHASE_W-1:0]             ddc_phase_inc,
    output logic                           phase_inc_valid,
    output logic                           mute,
    output logic                           busy,
    output logic [$clog2(TABLE_DEPTH)-1:0] hop_index,
    output logic [31:0]                    hop_count
);

    localparam int c_AW = $clog2(TABLE_DEPTH);
    localparam int c_LW = c_AW + 1;

    hop_state_t          r_state;
    logic [c_AW-1:0]     r_idx;
    logic [c_LW-1:0]     r_hop_len;
    logic [DWELL_W-1:0]  r_dwell_m1;
    logic [GUARD_W-1:0]  r_guard_m1;
    logic                r_guard_zero;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [GUARD_W-1:0]  r_guard_cnt;
    logic [PHASE_W-1:0]  r_phase;
    logic                r_valid;
    logic                r_mute;
    logic                r_busy;
    logic [c_AW-1:0]     r_hop_index;
    logic [31:0]         r_hop_count;

    logic [PHASE_W-1:0]  w_rd_data;
    logic [c_LW-1:0]     w_hop_len_clamped;
    logic                w_last_idx;
    logic [c_AW-1:0]     w_next_idx;
    logic                w_start_go;
    logic                w_hop_done;

    hop_table_ram #(
        .DEPTH (TABLE_DEPTH),
        .WIDTH (PHASE_W)
    ) u_table (
        .i_clock   (clock),
        .i_wr_en   (cfg_we),
        .i_wr_addr (cfg_addr),
        .i_wr_data (cfg_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_start_go = (r_state == S_IDLE) && start && !stop;
    assign w_hop_done = (r_state == S_DWELL) && (r_dwell_cnt == '0) && !stop;
    assign w_last_idx = ({1'b0, r_idx} == (r_hop_len - c_LW'(1)));

    // Clamp the requested table length into 1..TABLE_DEPTH
    always_comb begin
        w_hop_len_clamped = hop_len;
        if (hop_len == '0) begin
            w_hop_len_clamped = c_LW'(1);
        end else if (hop_len > c_LW'(TABLE_DEPTH)) begin
            w_hop_len_clamped = c_LW'(TABLE_DEPTH);
        end
    end

`ifdef DDC_HOP_PRBS_ORDER_EN
    logic [6:0]  r_lfsr;
    logic [6:0]  w_lfsr_next;
    logic [31:0] w_rem;

    assign w_lfsr_next = {r_lfsr[5:0], ^(r_lfsr & c_lfsr_taps)};

    // Next entry = advanced LFSR mod hop length, never the current entry
    always_comb begin
        w_rem = mod_by_subtract(32'(w_lfsr_next), 32'(r_hop_len));
        if (w_rem == 32'(r_idx)) begin
            w_rem = w_last_idx ? 32'd0 : 32'(r_idx) + 32'd1;
        end
        w_next_idx = c_AW'(w_rem);
    end

    // LFSR reseeded at start and advanced once per completed hop
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_start_go) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_hop_done) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_next_idx = w_last_idx ? '0 : r_idx + c_AW'(1);
`endif

    // Hop FSM with counters and registered outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_hop_len    <= c_LW'(1);
            r_dwell_m1   <= '0;
            r_guard_m1   <= '0;
            r_guard_zero <= 1'b1;
            r_dwell_cnt  <= '0;
            r_guard_cnt  <= '0;
            r_phase      <= '0;
            r_valid      <= 1'b0;
            r_mute       <= 1'b1;
            r_busy       <= 1'b0;
            r_hop_index  <= '0;
            r_hop_count  <= '0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state != S_IDLE) && stop) begin
                // Abort: outputs hold, no retune is committed
                r_state <= S_IDLE;
                r_mute  <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_go) begin
                            r_hop_len    <= w_hop_len_clamped;
                            r_dwell_m1   <= (dwell_cycles == '0) ? '0
                                            : dwell_cycles - DWELL_W'(1);
                            r_guard_m1   <= guard_cycles - GUARD_W'(1);
                            r_guard_zero <= (guard_cycles == '0);
                            r_idx        <= '0;
                            r_hop_count  <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_APPLY;
                    end
                    S_APPLY: begin
                        r_phase     <= w_rd_data;
                        r_hop_index <= r_idx;
                        r_valid     <= 1'b1;
                        if (r_guard_zero) begin
                            r_dwell_cnt <= r_dwell_m1;
                            r_mute      <= 1'b0;
                            r_state     <= S_DWELL;
                        end else begin
                            r_guard_cnt <= r_guard_m1;
                            r_state     <= S_GUARD;
                        end
                    end
                    S_GUARD: begin
                        if (r_guard_cnt == '0) begin
                            r_dwell_cnt <= r_dwell_m1;
                            r_mute      <= 1'b0;
                            r_state     <= S_DWELL;
                        end else begin
                            r_guard_cnt <= r_guard_cnt - GUARD_W'(1);
                        end
                    end
                    S_DWELL: begin
                        if (r_dwell_cnt == '0) begin
                            r_hop_count <= r_hop_count + 32'd1;
                            r_idx       <= w_next_idx;
                            r_mute      <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_mute  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ddc_phase_inc   = r_phase;
    assign phase_inc_valid = r_valid;
    assign mute            = r_mute;
    assign busy            = r_busy;
    assign hop_index       = r_hop_index;
    assign hop_count       = r_hop_count;

endmodule

`default_nettype wire

// File: tb/tb_ddc_hop_scheduler.sv
//==============================================================================
// Module      : tb_ddc_hop_scheduler
// Description : Self-checking bench for ddc_hop_scheduler. Scenario records
//               are replayed against a timeline model of the hop schedule.
//               Honours DDC_HOP_PRBS_ORDER_EN for the expected hop order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ddc_hop_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [15:0] cfg_data;
    logic [AW:0] hop_len;
    logic [31:0] dwell_cycles;
    logic [15:0] guard_cycles;
    logic        start;
    logic        stop;
    logic [15:0] ddc_phase_inc;
    logic        phase_inc_valid;
    logic        mute;
    logic        busy;
    logic [AW-1:0] hop_index;
    logic [31:0] hop_count;

    always #5 clock = ~clock;

    ddc_hop_scheduler #(
        .TABLE_DEPTH (DEPTH),
        .PHASE_W     (16),
        .DWELL_W     (32),
        .GUARD_W     (16)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .hop_len         (hop_len),
        .dwell_cycles    (dwell_cycles),
        .guard_cycles    (guard_cycles),
        .start           (start),
        .stop            (stop),
        .ddc_phase_inc   (ddc_phase_inc),
        .phase_inc_valid (phase_inc_valid),
        .mute            (mute),
        .busy            (busy),
        .hop_index       (hop_index),
        .hop_count       (hop_count)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] shadow [DEPTH];
    logic [15:0] hold_phase = 16'h0;
    int          hold_idx   = 0;
    int          hold_count = 0;

    typedef struct {
        int hop_len;    // value driven on hop_len
        int dwell;      // value driven on dwell_cycles
        int guard;      // value driven on guard_cycles
        int exp_len;    // expected effective table length
        int exp_period; // expected hop period in cycles
        int nsamp;      // samples to observe before stopping
        int wr_s;       // sample at which a table write is issued (0 = none)
        int wr_addr;
        int wr_data;
        int stop_s;     // sample at which stop is asserted (0 = at nsamp)
        int rst_s;      // sample at which resetn pulses low (0 = none)
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @sample %0d: got 0x%0h expected 0x%0h", name, s, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic write_entry(input int addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = data;
        step();
        cfg_we = 1'b0;
        shadow[addr] = data;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".phase"}, 0, 32'(ddc_phase_inc), 32'h0);
        chk({tag, ".valid"}, 0, 32'(phase_inc_valid), 32'h0);
        chk({tag, ".mute"}, 0, 32'(mute), 32'h1);
        chk({tag, ".busy"}, 0, 32'(busy), 32'h0);
        chk({tag, ".index"}, 0, 32'(hop_index), 32'h0);
        chk({tag, ".count"}, 0, hop_count, 32'h0);
    endtask

    // Replays one scenario and compares every sample to the hop timeline:
    // hop h is loaded at sample 1+h*P, shows up at sample 3+h*P, is muted for
    // the guard, unmuted for the dwell, and counted once its dwell expires.
    task automatic run_vec(input int id, input vec_t v);
        int g, d, L, P, s_end, h, off, r, lfsr;
        int seq [512];
        logic [15:0] val [512];
        logic [15:0] e_phase;
        int e_idx, e_count;
        logic e_valid, e_mute;
        logic [15:0] last_phase;
        int last_idx, last_count;
        string tag;

        tag = $sformatf("v%0d", id);
        g = v.guard;
        d = (v.dwell == 0) ? 1 : v.dwell;
        L = v.exp_len;
        P = v.exp_period;

        seq[0] = 0;
        lfsr = 1;
        for (int k = 1; k < 512; k++) begin
`ifdef DDC_HOP_PRBS_ORDER_EN
            lfsr = ((lfsr << 1) | (((lfsr >> 6) ^ (lfsr >> 5)) & 1)) & 127;
            r = lfsr % L;
            if (r == seq[k-1]) r = (r + 1) % L;
            seq[k] = r;
`else
            seq[k] = k % L;
`endif
        end

        hop_len      = 5'(v.hop_len);
        dwell_cycles = 32'(v.dwell);
        guard_cycles = 16'(v.guard);
        start        = 1'b1;
        step();
        start = 1'b0;
        // Configuration changes while busy must have no effect
        hop_len      = 5'($urandom_range(0, 31));
        dwell_cycles = $urandom_range(0, 9);
        guard_cycles = 16'($urandom_range(0, 9));

        s_end = (v.stop_s != 0) ? v.stop_s : ((v.rst_s != 0) ? v.rst_s : v.nsamp);
        last_phase = hold_phase;
        last_idx   = hold_idx;
        last_count = 0;

        for (int s = 1; s <= s_end; s++) begin
            if ((s - 1) % P == 0) val[(s - 1) / P] = shadow[seq[(s - 1) / P]];
            if (s >= 3) begin
                h       = (s - 3) / P;
                off     = (s - 3) % P;
                e_phase = val[h];
                e_idx   = seq[h];
                e_valid = (off == 0);
                e_mute  = !(off >= g && off < g + d);
            end else begin
                e_phase = hold_phase;
                e_idx   = hold_idx;
                e_valid = 1'b0;
                e_mute  = 1'b1;
            end
            e_count = (s >= 3 + g + d) ? (s - 3 - g - d) / P + 1 : 0;

            chk({tag, ".phase"}, s, 32'(ddc_phase_inc), 32'(e_phase));
            chk({tag, ".index"}, s, 32'(hop_index), 32'(e_idx));
            chk({tag, ".valid"}, s, 32'(phase_inc_valid), 32'(e_valid));
            chk({tag, ".mute"}, s, 32'(mute), 32'(e_mute));
            chk({tag, ".busy"}, s, 32'(busy), 32'h1);
            chk({tag, ".count"}, s, hop_count, 32'(e_count));
            last_phase = e_phase;
            last_idx   = e_idx;
            last_count = e_count;

            if (s == v.wr_s) begin
                cfg_we   = 1'b1;
                cfg_addr = AW'(v.wr_addr);
                cfg_data = 16'(v.wr_data);
                shadow[v.wr_addr] = 16'(v.wr_data);
            end
            if (s == s_end) begin
                if (v.rst_s != 0) resetn = 1'b0;
                else stop = 1'b1;
            end
            step();
            cfg_we = 1'b0;
            stop   = 1'b0;
            resetn = 1'b1;
        end

        if (v.rst_s != 0) begin
            check_reset_values({tag, ".rst"});
            hold_phase = 16'h0;
            hold_idx   = 0;
            hold_count = 0;
        end else begin
            chk({tag, ".stop.phase"}, s_end + 1, 32'(ddc_phase_inc), 32'(last_phase));
            chk({tag, ".stop.index"}, s_end + 1, 32'(hop_index), 32'(last_idx));
            chk({tag, ".stop.valid"}, s_end + 1, 32'(phase_inc_valid), 32'h0);
            chk({tag, ".stop.mute"}, s_end + 1, 32'(mute), 32'h1);
            chk({tag, ".stop.busy"}, s_end + 1, 32'(busy), 32'h0);
            chk({tag, ".stop.count"}, s_end + 1, hop_count, 32'(last_count));
            hold_phase = last_phase;
            hold_idx   = last_idx;
            hold_count = last_count;
        end
        step();
    endtask

    initial begin
        vec_t rv;
        int lin, dr;

        //           len dw gd eL eP nsamp wr_s a  data      stop rst
        vecs[0] = '{  3, 4, 2, 3, 8,  35,  0, 0, 0,         0,  0};
        vecs[1] = '{  3, 0, 0, 3, 3,  20,  0, 0, 0,         0,  0};
        vecs[2] = '{  0, 0, 0, 1, 3,  15,  0, 0, 0,         0,  0};
        vecs[3] = '{  3, 4, 2, 3, 8,  35,  0, 0, 0,        11,  0};
        vecs[4] = '{  3, 4, 2, 3, 8,  40, 14, 1, 'hBEEF,    0,  0};
        vecs[5] = '{  3, 4, 2, 3, 8,  35,  0, 0, 0,         0,  6};
        vecs[6] = '{  3, 4, 2, 3, 8,  12,  0, 0, 0,         0,  0};
        vecs[7] = '{ 20, 1, 1,16, 4,  75,  0, 0, 0,         0,  0};
        vecs[8] = '{  5, 2, 1, 5, 5, 323,  0, 0, 0,         0,  0};
        vecs[9] = '{  1, 3, 0, 1, 5,  30,  0, 0, 0,         0,  0};

        resetn       = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        hop_len      = '0;
        dwell_cycles = '0;
        guard_cycles = '0;
        start        = 1'b0;
        stop         = 1'b0;
        @(negedge clock);
        step();
        step();
        check_reset_values("reset");
        resetn = 1'b1;

        write_entry(0, 16'h1000);
        write_entry(1, 16'h2000);
        write_entry(2, 16'h3000);
        for (int i = 3; i < DEPTH; i++) write_entry(i, 16'(16'h4000 + i * 16'h0111));

        // start together with stop in IDLE: stop wins, nothing begins
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop.busy", 1, 32'(busy), 32'h0);
        chk("startstop.mute", 1, 32'(mute), 32'h1);
        step();
        chk("startstop.busy2", 2, 32'(busy), 32'h0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Randomised scenarios with fresh table contents
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < DEPTH; i++) write_entry(i, 16'($urandom));
            lin = $urandom_range(0, 20);
            dr  = $urandom_range(0, 6);
            rv.hop_len    = lin;
            rv.dwell      = dr;
            rv.guard      = $urandom_range(0, 4);
            rv.exp_len    = (lin == 0) ? 1 : ((lin > DEPTH) ? DEPTH : lin);
            rv.exp_period = 2 + rv.guard + ((dr == 0) ? 1 : dr);
            rv.nsamp      = $urandom_range(10, 200);
            rv.wr_s       = $urandom_range(1, rv.nsamp);
            rv.wr_addr    = $urandom_range(0, DEPTH - 1);
            rv.wr_data    = $urandom_range(0, 65535);
            rv.stop_s     = 0;
            rv.rst_s      = 0;
            run_vec(10 + n, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
